// File: rtl/if_id_fifo.sv
// Fetch-to-decode buffer: a DEPTH-entry FIFO of {pc, inst, excp} that lets
// fetch run ahead of a stalled decode stage. An empty FIFO presents an
// all-zero (NOP) bubble to decode. flush discards everything in one cycle.
module if_id_fifo #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 1,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic [EXC_W-1:0]  if_excp,
  output logic              if_ready,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [EXC_W-1:0]  id_excp,
  output logic [PTR_W:0]    count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [EXC_W-1:0]  excp;
  } entry_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Handshake: readiness and validity come only from registered count, so
  // there is no combinational path from id_stall to if_ready or from if_* to id_*.
  assign if_ready = (count != FULL_CNT);
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & ~id_stall & ~flush;

  // Pointer and occupancy state; rst outranks flush, flush outranks push/pop.
  // NOTE: reset here is synchronous, sampled on the clock edge like any other
  // input, and all sequential state uses non-blocking assignments so every
  // register updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write on an accepted push.
  // NOTE: the array has no reset; entries are only observed when count marks
  // them valid, and leaving it unreset lets it map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: if_pc, inst: if_inst, excp: if_excp};
    end
  end

  // Head presentation: stored entry when valid, otherwise an all-zero bubble.
  // NOTE: every output is given a default first so no path through this block
  // can leave a value unassigned and infer a latch.
  always_comb begin
    head    = mem[rd_ptr];
    id_pc   = '0;
    id_inst = '0;
    id_excp = '0;
    if (id_valid) begin
      id_pc   = head.pc;
      id_inst = head.inst;
      id_excp = head.excp;
    end
  end

endmodule
